// File: rtl/mem_stage_store_align.sv
// EX/MEM pipeline register with store alignment, address-exception detection
// and a saturating committed-store counter. Outputs drive the data memory directly.
module mem_stage_store_align #(
  parameter int unsigned DM_WORDS = 4096,
  parameter int unsigned IDX_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iStall,
  input  logic             iFlush,
  input  logic [31:0]      iAddr,
  input  logic [31:0]      iRT,
  input  logic [31:0]      iPC8,
  input  logic [1:0]       iStType,
  input  logic [2:0]       iLdType,
  output logic [IDX_W-1:0] oDM_Addr,
  output logic [31:0]      oDM_Data,
  output logic [3:0]       oDM_BE,
  output logic [31:0]      oPC8,
  output logic [2:0]       oLdType,
  output logic [1:0]       oByteOff,
  output logic             oAdES,
  output logic             oAdEL,
  output logic [31:0]      oStoreCnt
);

  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_B = 2'b01, ST_H = 2'b10, ST_W = 2'b11} st_type_e;
  typedef enum logic [2:0] {
    LD_NONE = 3'b000, LD_B = 3'b001, LD_BU = 3'b010, LD_H = 3'b011,
    LD_HU = 3'b100, LD_W = 3'b101, LD_R6 = 3'b110, LD_R7 = 3'b111
  } ld_type_e;

  // One past the last legal byte address; 33 bits so the compare never wraps.
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       be_q, be_d, be_raw;
  logic [31:0]      pc8_q;
  logic [2:0]       ld_q, ld_d;
  logic [1:0]       off_q, off_d;
  logic             ades_q, ades_d;
  logic             adel_q, adel_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             oor, st_mis, ld_mis, is_st;

  // Decode the EX-stage access: lane replication, byte enables, exceptions.
  always_comb begin
    off_d  = iAddr[1:0];
    idx_d  = iAddr[IDX_W+1:2];
    oor    = {1'b0, iAddr} >= DM_BYTES;
    data_d = iRT;
    be_raw = '0;
    st_mis = 1'b0;
    ld_mis = 1'b0;
    ld_d   = LD_NONE;
    unique case (st_type_e'(iStType))
      ST_B: begin
        data_d = {4{iRT[7:0]}};
        be_raw = 4'b0001 << off_d;
      end
      ST_H: begin
        data_d = {2{iRT[15:0]}};
        be_raw = off_d[1] ? 4'b1100 : 4'b0011;
        st_mis = off_d[0];
      end
      ST_W: begin
        be_raw = 4'b1111;
        st_mis = |off_d;
      end
      default: ;
    endcase
    is_st  = iStType != ST_NONE;
    ades_d = is_st & (oor | st_mis);
    be_d   = ades_d ? '0 : be_raw;
    // A store owns the slot; any load type alongside it is dropped.
    if (!is_st) begin
      unique case (ld_type_e'(iLdType))
        LD_B, LD_BU: ld_d = iLdType;
        LD_H, LD_HU: begin
          ld_d   = iLdType;
          ld_mis = off_d[0];
        end
        LD_W: begin
          ld_d   = iLdType;
          ld_mis = |off_d;
        end
        default: ld_d = LD_NONE;
      endcase
    end
    adel_d = (ld_d != LD_NONE) & (oor | ld_mis);
    cnt_d  = ((be_d != '0) && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
  end

  // Pipeline register: flush beats stall; flush leaves the counter alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
      pc8_q  <= '0;
      ld_q   <= '0;
      off_q  <= '0;
      ades_q <= 1'b0;
      adel_q <= 1'b0;
      cnt_q  <= '0;
    end else if (iFlush) begin
      idx_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
      pc8_q  <= '0;
      ld_q   <= '0;
      off_q  <= '0;
      ades_q <= 1'b0;
      adel_q <= 1'b0;
    end else if (!iStall) begin
      idx_q  <= idx_d;
      data_q <= data_d;
      be_q   <= be_d;
      pc8_q  <= iPC8;
      ld_q   <= ld_d;
      off_q  <= off_d;
      ades_q <= ades_d;
      adel_q <= adel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign oDM_Addr  = idx_q;
  assign oDM_Data  = data_q;
  assign oDM_BE    = be_q;
  assign oPC8      = pc8_q;
  assign oLdType   = ld_q;
  assign oByteOff  = off_q;
  assign oAdES     = ades_q;
  assign oAdEL     = adel_q;
  assign oStoreCnt = cnt_q;

endmodule

// File: tb/tb_mem_stage_store_align.sv
// Randomized and directed bench for mem_stage_store_align against a
// size/alignment-based reference model of the EX/MEM register.
module tb_mem_stage_store_align;

  localparam int unsigned DM_WORDS = 4096;
  localparam int unsigned IDX_W    = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             iStall, iFlush;
  logic [31:0]      iAddr, iRT, iPC8;
  logic [1:0]       iStType;
  logic [2:0]       iLdType;
  logic [IDX_W-1:0] oDM_Addr;
  logic [31:0]      oDM_Data;
  logic [3:0]       oDM_BE;
  logic [31:0]      oPC8;
  logic [2:0]       oLdType;
  logic [1:0]       oByteOff;
  logic             oAdES, oAdEL;
  logic [31:0]      oStoreCnt;

  int checks = 0;
  int errors = 0;

  // Reference model state (what the outputs should show).
  logic [IDX_W-1:0] m_idx;
  logic [31:0]      m_data, m_pc8, m_cnt;
  logic [3:0]       m_be;
  logic [2:0]       m_ld;
  logic [1:0]       m_off;
  logic             m_ades, m_adel;

  mem_stage_store_align #(.DM_WORDS(DM_WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .iStall(iStall), .iFlush(iFlush),
    .iAddr(iAddr), .iRT(iRT), .iPC8(iPC8), .iStType(iStType), .iLdType(iLdType),
    .oDM_Addr(oDM_Addr), .oDM_Data(oDM_Data), .oDM_BE(oDM_BE), .oPC8(oPC8),
    .oLdType(oLdType), .oByteOff(oByteOff), .oAdES(oAdES), .oAdEL(oAdEL),
    .oStoreCnt(oStoreCnt)
  );

  always #5 clk = ~clk;

  function automatic void model_clear(input bit with_cnt);
    m_idx = '0; m_data = '0; m_be = '0; m_pc8 = '0; m_ld = '0; m_off = '0;
    m_ades = 1'b0; m_adel = 1'b0;
    if (with_cnt) m_cnt = '0;
  endfunction

  // Access described by its size in bytes; alignment = address divisible by size.
  function automatic void model_edge();
    longint unsigned a;
    int unsigned     sz, lsz;
    bit              in_rng;
    logic [7:0]      b;
    if (iFlush) begin model_clear(1'b0); return; end
    if (iStall) return;
    a      = longint'(iAddr);
    in_rng = a < longint'(DM_WORDS) * 4;
    sz     = (iStType == 2'd1) ? 1 : (iStType == 2'd2) ? 2 : (iStType == 2'd3) ? 4 : 0;
    lsz    = (iLdType == 3'd1 || iLdType == 3'd2) ? 1 :
             (iLdType == 3'd3 || iLdType == 3'd4) ? 2 : (iLdType == 3'd5) ? 4 : 0;
    m_idx  = IDX_W'((a / 4) % DM_WORDS);
    m_off  = 2'(a % 4);
    m_pc8  = iPC8;
    m_data = iRT;
    m_be   = '0;
    m_ades = 1'b0;
    m_adel = 1'b0;
    m_ld   = '0;
    if (sz != 0) begin
      m_ades = !(in_rng && (a % sz) == 0);
      for (int k = 0; k < 4; k++) begin
        b = 8'(iRT >> (8 * (k % sz)));
        m_data[8*k +: 8] = b;
      end
      if (!m_ades) m_be = 4'(((1 << sz) - 1) << (a % 4));
      if (m_be != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (lsz != 0) begin
      m_ld   = iLdType;
      m_adel = !(in_rng && (a % lsz) == 0);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [1:0] st, input logic [2:0] ld, input logic [31:0] addr,
                       input logic [31:0] rt);
    iStType = st; iLdType = ld; iAddr = addr; iRT = rt; iPC8 = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b0; iStall = 0; iFlush = 0;
    drive(2'd0, 3'd0, 32'h0, 32'h0);
    m_cnt = '0; model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive(2'd3, 3'd0, 32'h40, 32'hCAFE_F00D); step();
    drive(2'd1, 3'd0, 32'h41, 32'h55); step();
    checks++; if (oStoreCnt !== m_cnt) begin errors++;
      $display("FAIL rst_precnt got=%h exp=%h", oStoreCnt, m_cnt); end
    reset = 1'b0; #1;
    model_clear(1'b1);
    checks++; if ({oDM_Addr, oDM_Data, oDM_BE, oPC8, oLdType, oByteOff, oAdES, oAdEL, oStoreCnt} !== '0) begin
      errors++; $display("FAIL rst_async got be=%b data=%h cnt=%h pc8=%h exp all 0", oDM_BE, oDM_Data, oStoreCnt, oPC8); end
    @(negedge clk) reset = 1'b1;
    drive(2'd0, 3'd5, 32'h0000_0108, 32'h0); step();
    checks++; if (oLdType !== 3'b101 || oDM_Addr !== 12'h042 || oAdEL !== 1'b0 || oPC8 !== m_pc8 || oStoreCnt !== 32'd0) begin
      errors++; $display("FAIL rst_first ld=%b idx=%h adel=%b pc8=%h cnt=%h exp ld=101 idx=042 adel=0 pc8=%h cnt=0",
                         oLdType, oDM_Addr, oAdEL, oPC8, oStoreCnt, m_pc8); end
  endtask

  task automatic test_sb();
    drive(2'd1, 3'd0, 32'h0000_0013, 32'h1234_56AB); step();
    checks++; if (oDM_Addr !== 12'h004 || oDM_Data !== 32'hABAB_ABAB || oDM_BE !== 4'b1000 || oStoreCnt !== 32'd1 || oByteOff !== 2'd3) begin
      errors++; $display("FAIL sb idx=%h data=%h be=%b cnt=%h off=%0d exp 004 ABABABAB 1000 1 3",
                         oDM_Addr, oDM_Data, oDM_BE, oStoreCnt, oByteOff); end
  endtask

  task automatic test_sh();
    logic [31:0] rt;
    rt = $urandom;
    drive(2'd2, 3'd0, 32'h0000_0102, rt); step();
    checks++; if (oDM_BE !== 4'b1100 || oDM_Data !== {2{rt[15:0]}} || oAdES !== 1'b0 || oStoreCnt !== 32'd2) begin
      errors++; $display("FAIL sh_ok be=%b data=%h ades=%b cnt=%h exp 1100 %h 0 2", oDM_BE, oDM_Data, oAdES, oStoreCnt, {2{rt[15:0]}}); end
    drive(2'd2, 3'd0, 32'h0000_0101, rt); step();
    checks++; if (oDM_BE !== 4'b0000 || oAdES !== 1'b1 || oAdEL !== 1'b0 || oStoreCnt !== 32'd2) begin
      errors++; $display("FAIL sh_mis be=%b ades=%b adel=%b cnt=%h exp 0000 1 0 2", oDM_BE, oAdES, oAdEL, oStoreCnt); end
  endtask

  task automatic test_range();
    drive(2'd3, 3'd5, 32'h0000_4000, 32'h1111_2222); step();
    checks++; if (oAdES !== 1'b1 || oDM_BE !== 4'b0000 || oAdEL !== 1'b0 || oLdType !== 3'd0) begin
      errors++; $display("FAIL sw_oor ades=%b be=%b adel=%b ld=%b exp 1 0000 0 000", oAdES, oDM_BE, oAdEL, oLdType); end
    drive(2'd0, 3'd5, 32'h0000_3FFC, 32'h0); step();
    checks++; if (oAdEL !== 1'b0 || oLdType !== 3'b101 || oDM_Addr !== 12'hFFF) begin
      errors++; $display("FAIL lw_top adel=%b ld=%b idx=%h exp 0 101 FFF", oAdEL, oLdType, oDM_Addr); end
    drive(2'd0, 3'd5, 32'hFFFF_FFFC, 32'h0); step();
    checks++; if (oAdEL !== 1'b1) begin
      errors++; $display("FAIL lw_wrap adel=%b exp 1", oAdEL); end
    drive(2'd1, 3'd0, 32'h0000_3FFF, 32'h0000_00C3); step();
    checks++; if (oDM_BE !== 4'b1000 || oAdES !== 1'b0 || oDM_Data !== 32'hC3C3_C3C3 || oStoreCnt !== m_cnt) begin
      errors++; $display("FAIL sb_top be=%b ades=%b data=%h cnt=%h exp 1000 0 C3C3C3C3 %h", oDM_BE, oAdES, oDM_Data, oStoreCnt, m_cnt); end
    drive(2'd0, 3'd3, 32'h0000_0203, 32'h0); step();
    checks++; if (oAdEL !== 1'b1 || oLdType !== 3'b011) begin
      errors++; $display("FAIL lh_mis adel=%b ld=%b exp 1 011", oAdEL, oLdType); end
    drive(2'd0, 3'd7, 32'h0000_0203, 32'h0); step();
    checks++; if (oAdEL !== 1'b0 || oLdType !== 3'b000) begin
      errors++; $display("FAIL ld_rsv adel=%b ld=%b exp 0 000", oAdEL, oLdType); end
  endtask

  task automatic test_stall();
    logic [31:0] c0, pc;
    c0 = m_cnt;
    drive(2'd3, 3'd0, 32'h0000_0020, 32'hDEAD_BEEF); pc = iPC8; step();
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 3'd0, 32'($urandom_range(0, 32'h3FFF)), $urandom); step();
      checks++; if (oDM_BE !== 4'hF || oDM_Data !== 32'hDEAD_BEEF || oDM_Addr !== 12'h008 || oPC8 !== pc || oStoreCnt !== c0 + 1) begin
        errors++; $display("FAIL stall%0d be=%b data=%h idx=%h pc8=%h cnt=%h exp F DEADBEEF 008 %h %h",
                           i, oDM_BE, oDM_Data, oDM_Addr, oPC8, oStoreCnt, pc, c0 + 1); end
    end
    iFlush = 1'b1; step();
    checks++; if (oDM_BE !== 4'b0000 || oPC8 !== 32'd0 || oDM_Data !== 32'd0 || oStoreCnt !== c0 + 1) begin
      errors++; $display("FAIL stall_flush be=%b pc8=%h data=%h cnt=%h exp 0000 0 0 %h", oDM_BE, oPC8, oDM_Data, oStoreCnt, c0 + 1); end
    iStall = 1'b0; iFlush = 1'b0;
  endtask

  task automatic test_random();
    int unsigned mode;
    for (int n = 0; n < 400; n++) begin
      iStall = ($urandom_range(0, 7) == 0);
      iFlush = ($urandom_range(0, 15) == 0);
      mode = $urandom_range(0, 2);
      drive(2'($urandom), 3'($urandom),
            (mode == 0) ? ($urandom & 32'h3FFF) : (mode == 1) ? 32'($urandom_range(32'h3FF0, 32'h400F)) : $urandom,
            $urandom);
      step();
      checks++; if (oDM_Addr !== m_idx) begin errors++; $display("FAIL rnd_idx n=%0d got=%h exp=%h", n, oDM_Addr, m_idx); end
      checks++; if (oDM_Data !== m_data) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, oDM_Data, m_data); end
      checks++; if (oDM_BE !== m_be) begin errors++; $display("FAIL rnd_be n=%0d got=%b exp=%b", n, oDM_BE, m_be); end
      checks++; if (oPC8 !== m_pc8) begin errors++; $display("FAIL rnd_pc8 n=%0d got=%h exp=%h", n, oPC8, m_pc8); end
      checks++; if (oLdType !== m_ld) begin errors++; $display("FAIL rnd_ld n=%0d got=%b exp=%b", n, oLdType, m_ld); end
      checks++; if (oByteOff !== m_off) begin errors++; $display("FAIL rnd_off n=%0d got=%0d exp=%0d", n, oByteOff, m_off); end
      checks++; if (oAdES !== m_ades) begin errors++; $display("FAIL rnd_ades n=%0d got=%b exp=%b", n, oAdES, m_ades); end
      checks++; if (oAdEL !== m_adel) begin errors++; $display("FAIL rnd_adel n=%0d got=%b exp=%b", n, oAdEL, m_adel); end
      checks++; if (oStoreCnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d got=%h exp=%h", n, oStoreCnt, m_cnt); end
    end
    iStall = 1'b0; iFlush = 1'b0;
  endtask

  task automatic test_saturate();
    drive(2'd0, 3'd0, 32'h0, 32'h0);
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    checks++; if (oStoreCnt !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sat_preload got=%h exp=FFFFFFFE", oStoreCnt); end
    drive(2'd3, 3'd0, 32'h0000_0100, $urandom); step();
    checks++; if (oStoreCnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_reach got=%h exp=FFFFFFFF", oStoreCnt); end
    drive(2'd3, 3'd0, 32'h0000_0104, $urandom); step();
    drive(2'd1, 3'd0, 32'h0000_0105, $urandom); step();
    checks++; if (oStoreCnt !== 32'hFFFF_FFFF || oDM_BE !== 4'b0010) begin
      errors++; $display("FAIL sat_hold cnt=%h be=%b exp FFFFFFFF 0010", oStoreCnt, oDM_BE); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_range();
    test_stall();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
